// File: rtl/index_unfold_pp.sv
// Double-buffered sparse-to-dense row unfolder: lane words scatter into the write bank,
// and a streaming reader drains the other bank densely, zeroing each word as it goes.
module index_unfold_pp #(
  parameter int LANES       = 5,
  parameter int IDX_W       = 8,
  parameter int DATA_W      = 24,
  parameter int ROW_LENGTH  = 28,
  parameter int FILTER_SIZE = 5,
  parameter int DEPTH       = ROW_LENGTH - FILTER_SIZE + 1,
  parameter int CNT_W       = $clog2(LANES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CNT_W-1:0]               in_count,
  input  logic [LANES*(IDX_W+DATA_W)-1:0] in_data,
  input  logic                           acc_en,
  input  logic                           row_fini,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_idx,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_last,
  output logic                           oor_err,
  output logic                           fini_ovf
);

  localparam int                WORD_W   = IDX_W + DATA_W;
  localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LANES_C  = CNT_W'(LANES);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_r;
  logic              wr_sel_r;
  logic              fini_pend_r;
  logic              oor_err_r;
  logic              fini_ovf_r;
  logic [IDX_W-1:0]  out_idx_r;
  logic [DATA_W-1:0] bank_r [2][DEPTH];

  logic [CNT_W-1:0]  cnt_s;
  logic [IDX_W-1:0]  lane_idx_s [LANES];
  logic [DATA_W-1:0] lane_val_s [LANES];
  logic [LANES-1:0]  lane_vld_s;
  logic [LANES-1:0]  lane_oor_s;
  logic [DEPTH-1:0]  wr_hit_s;
  logic [DATA_W-1:0] wr_next_s [DEPTH];
  logic [AW-1:0]     rd_addr_s;
  logic              accept_s;
  logic              hs_s;
  logic              last_hs_s;
  logic              swap_s;

  assign cnt_s     = (in_count > LANES_C) ? LANES_C : in_count;
  assign accept_s  = in_valid && !fini_pend_r;
  assign hs_s      = (state_r == DRAIN) && out_ready;
  assign last_hs_s = hs_s && (out_idx_r == LAST_IDX);
  // A pending or coincident row_fini at the last handshake swaps without a gap
  assign swap_s    = ((state_r == IDLE) && row_fini) || (last_hs_s && (fini_pend_r || row_fini));
  assign rd_addr_s = out_idx_r[AW-1:0];

  // Lane unpacking; valid lanes are the top in_count lanes
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_idx_s[k] = in_data[k*WORD_W + DATA_W +: IDX_W];
      lane_val_s[k] = in_data[k*WORD_W +: DATA_W];
      lane_vld_s[k] = (k + int'(cnt_s)) >= LANES;
      lane_oor_s[k] = lane_vld_s[k] && (int'(lane_idx_s[k]) >= DEPTH);
    end
  end

  // Per-word merge: highest lane wins on overwrite, all matching lanes add on accumulate
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      logic              hit_v;
      logic              hit_k;
      logic [DATA_W-1:0] ovw_v;
      logic [DATA_W-1:0] acc_v;
      hit_v = 1'b0;
      hit_k = 1'b0;
      ovw_v = '0;
      acc_v = bank_r[wr_sel_r][j];
      for (int k = 0; k < LANES; k++) begin
        hit_k = lane_vld_s[k] && (lane_idx_s[k] == IDX_W'(j));
        hit_v = hit_v | hit_k;
        ovw_v = hit_k ? lane_val_s[k] : ovw_v;
        acc_v = acc_v + (hit_k ? lane_val_s[k] : {DATA_W{1'b0}});
      end
      wr_hit_s[j]  = accept_s && hit_v;
      wr_next_s[j] = acc_en ? acc_v : ovw_v;
    end
  end

  // Bank storage: writes land in the write bank, drained words in the read bank are zeroed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int j = 0; j < DEPTH; j++)
          bank_r[b][j] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (1'(b) == wr_sel_r) begin
            if (wr_hit_s[j]) bank_r[b][j] <= wr_next_s[j];
          end else begin
            if (hs_s && (rd_addr_s == AW'(j))) bank_r[b][j] <= '0;
          end
        end
      end
    end
  end

  // Reader FSM, bank select, pending swap and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      wr_sel_r    <= 1'b0;
      out_idx_r   <= '0;
      fini_pend_r <= 1'b0;
      oor_err_r   <= 1'b0;
      fini_ovf_r  <= 1'b0;
    end else begin
      oor_err_r  <= oor_err_r | (accept_s & (|lane_oor_s));
      fini_ovf_r <= fini_ovf_r | (row_fini & fini_pend_r);
      if (swap_s) wr_sel_r <= ~wr_sel_r;
      case (state_r)
        IDLE: begin
          if (row_fini) begin
            state_r   <= DRAIN;
            out_idx_r <= '0;
          end
        end
        DRAIN: begin
          if (last_hs_s) begin
            out_idx_r   <= '0;
            fini_pend_r <= 1'b0;
            state_r     <= (fini_pend_r || row_fini) ? DRAIN : IDLE;
          end else begin
            if (hs_s) out_idx_r <= out_idx_r + IDX_W'(1);
            if (row_fini && !fini_pend_r) fini_pend_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = !fini_pend_r;
  assign out_valid = (state_r == DRAIN);
  assign out_idx   = out_idx_r;
  assign out_data  = (state_r == DRAIN) ? bank_r[~wr_sel_r][rd_addr_s] : '0;
  assign out_last  = (state_r == DRAIN) && (out_idx_r == LAST_IDX);
  assign oor_err   = oor_err_r;
  assign fini_ovf  = fini_ovf_r;

endmodule

// File: tb/tb_index_unfold_pp.sv
// Scoreboard bench for index_unfold_pp: a row model is pushed on every accepted row_fini
// and popped by a monitor on each output handshake.
module tb_index_unfold_pp;
  localparam int LANES = 5;
  localparam int IDX_W = 8;
  localparam int DATA_W = 24;
  localparam int DEPTH = 24;
  localparam int CNT_W = 3;
  localparam int LW = IDX_W + DATA_W;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_ready, acc_en, row_fini;
  logic [CNT_W-1:0]      in_count;
  logic [LANES*LW-1:0]   in_data;
  logic                  out_valid, out_ready, out_last, oor_err, fini_ovf;
  logic [IDX_W-1:0]      out_idx;
  logic [DATA_W-1:0]     out_data;

  exp_t              sb[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  logic              exp_oor, exp_ovf;
  int                vectors = 0;
  int                errors = 0;

  index_unfold_pp dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_data(in_data), .acc_en(acc_en), .row_fini(row_fini),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_last(out_last), .oor_err(oor_err), .fini_ovf(fini_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lw(input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] v);
    return {i, v};
  endfunction

  // Output monitor: every handshake pops and compares one expected word
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: got idx=%0d data=%h, required no word", out_idx, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_idx, out_data, out_last} !== {e.idx, e.data, e.last}) begin
          errors++;
          $display("FAIL stream_word: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   out_idx, out_data, out_last, e.idx, e.data, e.last);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // One cycle of stimulus; open = bench expects in_ready high (no pending swap)
  task automatic step(input bit vld, input int cnt, input bit acc, input logic [LANES*LW-1:0] data,
                      input bit fin, input bit open);
    int ce;
    in_valid = vld; in_count = CNT_W'(cnt); acc_en = acc; in_data = data; row_fini = fin;
    vectors++;
    if (in_ready !== open) begin
      errors++;
      $display("FAIL in_ready: got %b, required %b", in_ready, open);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; row_fini = 1'b0;
    ce = (cnt > LANES) ? LANES : cnt;
    if (vld && open) begin
      for (int k = LANES - ce; k < LANES; k++) begin
        logic [IDX_W-1:0]  ix;
        logic [DATA_W-1:0] v;
        ix = data[k*LW + DATA_W +: IDX_W];
        v  = data[k*LW +: DATA_W];
        if (ix >= IDX_W'(DEPTH)) exp_oor = 1'b1;
        else if (acc) mdl[ix] = mdl[ix] + v;
        else mdl[ix] = v;
      end
    end
    if (fin && open) begin
      for (int i = 0; i < DEPTH; i++) sb.push_back({IDX_W'(i), mdl[i], i == DEPTH - 1});
      clear_model();
    end else if (fin) begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0", sb.size());
      sb.delete();
    end else if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end_valid: got %b, required 0", out_valid);
    end
  endtask

  task automatic check_flags(input string name);
    vectors++;
    if ({oor_err, fini_ovf} !== {exp_oor, exp_ovf}) begin
      errors++;
      $display("FAIL %s: got oor=%b ovf=%b, required oor=%b ovf=%b", name, oor_err, fini_ovf, exp_oor, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_count = '0; in_data = '0; acc_en = 1'b0;
    row_fini = 1'b0; out_ready = 1'b1; exp_oor = 1'b0; exp_ovf = 1'b0;
    clear_model();
    #2 rst = 1'b0;
    #2;
    vectors++;
    if ({in_ready, out_valid, out_idx, out_data, out_last, oor_err, fini_ovf} !==
        {1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b idx=%0d data=%h last=%b oor=%b ovf=%b",
               in_ready, out_valid, out_idx, out_data, out_last, oor_err, fini_ovf);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_one_beat();
    step(1, 2, 0, {lw(3, 24'hABCDEF), lw(7, 24'h000011), lw(5, 24'h55), lw(5, 24'h66), lw(5, 24'h77)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    vectors++;
    if ({out_valid, out_idx} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL fini_latency: got vld=%b idx=%0d, required vld=1 idx=0", out_valid, out_idx);
    end
    wait_drain();
  endtask

  task automatic test_collision();
    logic [LANES*LW-1:0] d;
    d = {lw(5, 24'd5), lw(5, 24'd4), lw(5, 24'd3), lw(5, 24'd2), lw(5, 24'd1)};
    step(1, 5, 0, d, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    wait_drain();
    step(1, 7, 1, d, 0, 1);
    step(1, 1, 0, {lw(9, 24'hFFFFFF), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(1, 1, 1, {lw(9, 24'h000002), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 1, 1);
    wait_drain();
  endtask

  task automatic test_oor();
    step(1, 2, 0, {lw(30, 24'h5), lw(2, 24'd9), lw(0, 24'h1), lw(0, 24'h1), lw(0, 24'h1)}, 0, 1);
    check_flags("oor_set");
    step(0, 0, 0, '0, 1, 1);
    wait_drain();
    check_flags("oor_sticky");
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b0;
    step(1, 2, 0, {lw(0, 24'h123), lw(23, 24'h777), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    idle(10);
    vectors++;
    if ({out_valid, out_idx, out_data} !== {1'b1, 8'd0, 24'h123}) begin
      errors++;
      $display("FAIL stall_hold: got vld=%b idx=%0d data=%h, required vld=1 idx=0 data=000123",
               out_valid, out_idx, out_data);
    end
    step(1, 1, 0, {lw(2, 24'h222), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(1, 1, 0, {lw(5, 24'hBAD), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 0);
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); n++; #1;
      if (sb.size() == 0) break;
    end
    vectors++;
    if ({n, in_ready, out_valid} !== {2 * DEPTH, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pingpong_contig: got cycles=%0d rdy=%b vld=%b, required cycles=%0d rdy=1 vld=0",
               n, in_ready, out_valid, 2 * DEPTH);
    end
    step(0, 0, 0, '0, 1, 1);
    wait_drain();
  endtask

  task automatic test_fini_ovf();
    out_ready = 1'b0;
    step(1, 1, 0, {lw(4, 24'hA), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(1, 1, 0, {lw(6, 24'hB), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(0, 0, 0, '0, 1, 0);
    check_flags("fini_ovf_set");
    out_ready = 1'b1;
    wait_drain();
    idle(5);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_rows_only: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    int i;
    step(1, 1, 0, {lw(10, 24'h5A5A), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    step(1, 1, 0, {lw(15, 24'h99), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    for (i = 0; i < 100; i++) begin
      if (out_idx == 8'd12) break;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({i < 100, in_ready, out_valid, out_idx, out_data, out_last, oor_err, fini_ovf} !==
        {1'b1, 1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_drain_reset: got reached=%b rdy=%b vld=%b idx=%0d data=%h last=%b oor=%b ovf=%b",
               i < 100, in_ready, out_valid, out_idx, out_data, out_last, oor_err, fini_ovf);
    end
    sb.delete();
    clear_model();
    exp_oor = 1'b0; exp_ovf = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 0, {lw(20, 24'h42), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0), lw(0, 24'h0)}, 0, 1);
    step(0, 0, 0, '0, 1, 1);
    wait_drain();
    check_flags("flags_after_reset");
  endtask

  initial begin
    test_reset();
    test_one_beat();
    test_collision();
    test_oor();
    test_back_to_back();
    test_fini_ovf();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/index_unfold_pp.md
# index_unfold_pp

Parametrised, double-buffered sparse-to-dense row unfolder. Each accepted beat carries up to LANES packed {index, value} words that are scattered into the active row bank. On `row_fini` the bank is handed to a streaming reader, which emits the dense row (index 0..DEPTH-1) under valid/ready and zeroes each word as it is read. The block sits between the index-pop stage and the convolution row consumer and replaces the single-bank, file-initialised unfold memory.

## Interface
- LANES, 5, word lanes per input beat
- IDX_W, 8, index field width (upper bits of each lane word)
- DATA_W, 24, value field width (lower bits of each lane word)
- ROW_LENGTH, 28, input row length
- FILTER_SIZE, 5, filter width
- DEPTH, ROW_LENGTH-FILTER_SIZE+1 (24), words per row bank; must be ≤ 2^IDX_W
- CNT_W, $clog2(LANES+1), width of in_count

Ports (lane k occupies bits [k*(IDX_W+DATA_W) +: IDX_W+DATA_W], index in the upper IDX_W bits):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  write bank open
- in_count  in  CNT_W  number of valid lanes; the valid lanes are the top ones, LANES-1 down to LANES-in_count; values > LANES are treated as LANES
- in_data  in  LANES*(IDX_W+DATA_W)  packed lane words
- acc_en  in  1  0 = overwrite, 1 = accumulate; sampled per beat
- row_fini  in  1  one-cycle pulse closing the current row
- out_valid  out  1  dense word valid
- out_ready  in  1  consumer ready
- out_idx  out  IDX_W  index of the word currently on out_data
- out_data  out  DATA_W  dense value
- out_last  out  1  high with out_idx == DEPTH-1
- oor_err  out  1  sticky flag: a lane index was ≥ DEPTH
- fini_ovf  out  1  sticky flag: a row_fini was dropped

## Operation
- Two banks, each DEPTH×DATA_W registers. wr_sel selects the write bank; the other bank is the read bank.
- Beat accepted when in_valid && in_ready. Each valid lane with idx < DEPTH writes its bank word. In overwrite mode, when several lanes target the same index, the highest-numbered lane wins. In accumulate mode, the result is the old word plus all matching lanes, modulo 2^DATA_W.
- A lane with idx ≥ DEPTH is dropped and sets oor_err. The other lanes of that beat still write.
- Reader FSM:
  - IDLE (reset state).
  - DRAIN: out_valid=1, out_data = read_bank[out_idx]. Each handshake clears that word and increments out_idx. The handshake at DEPTH-1 ends the drain.
- row_fini while the reader is IDLE: swap wr_sel, enter DRAIN at out_idx 0.
- row_fini while the reader is in DRAIN: latch fini_pend. in_ready drops to 0 (both banks are occupied). At the last-word handshake, swap, clear fini_pend and restart DRAIN at index 0. out_valid stays high back-to-back.
- row_fini while fini_pend=1: ignored; sets fini_ovf.
- row_fini in the same cycle as an accepted beat: the beat is written into the closing row before the swap.
- Reset clears both banks, wr_sel=0, reader IDLE, fini_pend=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_data=0, out_last=0, oor_err=0, fini_ovf=0.
- Write latency: a beat accepted at edge t is readable in the bank from t+1.
- row_fini at edge t with reader IDLE: out_valid=1 and out_idx=0 from t+1. With out_ready held high, the row drains in exactly DEPTH cycles, out_last is high in cycle t+DEPTH, and out_valid drops at t+DEPTH+1 unless a swap is pending.
- out_data is a combinational read of registers, valid in the same cycle as out_valid. It is held stable while out_valid && !out_ready.
- in_ready returns to 1 in the cycle after the pending swap edge.
- Reset asserted mid-drain aborts the drain immediately. All outputs take their reset values asynchronously.

## Test plan
- Reset, one beat: in_count=2, lane4={3,0xABCDEF}, lane3={7,0x000011}, then row_fini → 24 words streamed; idx3=0xABCDEF, idx7=0x11, all others 0; out_last on idx 23.
- Collision: lanes 0..4 all target idx 5, values 1..5. With acc_en=0, word 5 reads 5. With acc_en=1, word 5 reads 15. Accumulate wrap: 0xFFFFFF + 2 reads 0x000001.
- Out-of-range: lane4 idx=30 plus lane3 idx=2 value 9 → oor_err=1 and stays 1; word 2 reads 9; no other word changes.
- Back-pressure and ping-pong: hold out_ready=0 for 10 cycles during a drain, then row_fini → in_ready=0 until the last handshake; second row streams contiguously; first bank re-read shows all zeros.
- Third row_fini while fini_pend=1 → fini_ovf=1; only two rows are emitted.
- Assert rst at drain index 12 → outputs reset; the next row_fini streams only the newly written data.
